// File: rtl/any1_ialign_q.sv
// Cache-line instruction aligner: walks an accepted line slot by slot and queues
// fixed-width instructions (or a single alignment-fault word) for decode.
module any1_ialign_q #(
  parameter int unsigned LINE_BITS = 512,
  parameter int unsigned INSN_BITS = 64,
  parameter int unsigned AWID      = 32,
  parameter int unsigned RID_W     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  FLT_CODE  = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       line_valid_i,
  output logic                       line_ready_o,
  input  logic [LINE_BITS-1:0]       cacheline_i,
  input  logic [AWID-1:0]            ip_i,
  input  logic [AWID-1:0]            pip_i,
  input  logic [RID_W-1:0]           rid_i,
  input  logic                       stream_i,
  input  logic                       predict_taken_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [INSN_BITS-1:0]       ir_o,
  output logic [AWID-1:0]            ip_o,
  output logic [AWID-1:0]            pip_o,
  output logic [RID_W-1:0]           rid_o,
  output logic                       stream_o,
  output logic                       predict_taken_o,
  output logic                       fault_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned IB     = INSN_BITS / 8;
  localparam int unsigned SLOTS  = LINE_BITS / INSN_BITS;
  localparam int unsigned OFS_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned IBW    = $clog2(IB);
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [INSN_BITS-1:0] FLT_WORD = INSN_BITS'({FLT_CODE, 16'h0000});

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWalk = 1'b1;

  logic [0:0]                        state_q, state_d;
  logic [SLOTS-1:0][INSN_BITS-1:0]   line_q, line_d;
  logic [AWID-1:0]                   cur_ip_q, cur_ip_d;
  logic [SLOT_W-1:0]                 slot_q, slot_d;
  logic [AWID-1:0]                   pip_q, pip_d;
  logic [RID_W-1:0]                  rid_q, rid_d;
  logic                              stream_q, stream_d;
  logic                              pt_q, pt_d;
  logic                              flt_q, flt_d;

  logic [OFS_W-1:0]                  ofs;
  logic                              full, push, pop, last_push;
  logic [INSN_BITS-1:0]              push_ir;

  logic [INSN_BITS-1:0]              ir_mem     [DEPTH];
  logic [AWID-1:0]                   ip_mem     [DEPTH];
  logic [AWID-1:0]                   pip_mem    [DEPTH];
  logic [RID_W-1:0]                  rid_mem    [DEPTH];
  logic                              stream_mem [DEPTH];
  logic                              pt_mem     [DEPTH];
  logic                              flt_mem    [DEPTH];
  logic [PTR_W-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                  count_q;

  assign ofs          = ip_i[OFS_W-1:0];
  assign full         = (count_q == CNT_W'(DEPTH));
  assign pop          = out_valid_o && out_ready_i;
  assign push         = (state_q == StWalk) && !full && !flush_i;
  assign last_push    = flt_q || pt_q || (slot_q == SLOT_W'(SLOTS - 1));
  assign push_ir      = flt_q ? FLT_WORD : line_q[slot_q];
  assign line_ready_o = (state_q == StIdle);

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    cur_ip_d = cur_ip_q;
    slot_d   = slot_q;
    pip_d    = pip_q;
    rid_d    = rid_q;
    stream_d = stream_q;
    pt_d     = pt_q;
    flt_d    = flt_q;
    if (flush_i) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (line_valid_i) begin
        state_d  = StWalk;
        line_d   = cacheline_i;
        cur_ip_d = ip_i;
        slot_d   = SLOT_W'(ofs >> IBW);
        pip_d    = pip_i;
        rid_d    = rid_i;
        stream_d = stream_i;
        pt_d     = predict_taken_i;
        flt_d    = |ofs[IBW-1:0];
      end
    end else if (!full) begin
      cur_ip_d = cur_ip_q + AWID'(IB);
      if (last_push) begin
        state_d = StIdle;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      line_q   <= '0;
      cur_ip_q <= '0;
      slot_q   <= '0;
      pip_q    <= '0;
      rid_q    <= '0;
      stream_q <= 1'b0;
      pt_q     <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      cur_ip_q <= cur_ip_d;
      slot_q   <= slot_d;
      pip_q    <= pip_d;
      rid_q    <= rid_d;
      stream_q <= stream_d;
      pt_q     <= pt_d;
      flt_q    <= flt_d;
    end
  end

  // Push is refused on a full queue even when the head is popped the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ir_mem[i]     <= '0;
        ip_mem[i]     <= '0;
        pip_mem[i]    <= '0;
        rid_mem[i]    <= '0;
        stream_mem[i] <= 1'b0;
        pt_mem[i]     <= 1'b0;
        flt_mem[i]    <= 1'b0;
      end
    end else if (push) begin
      ir_mem[wr_ptr_q]     <= push_ir;
      ip_mem[wr_ptr_q]     <= cur_ip_q;
      pip_mem[wr_ptr_q]    <= pip_q;
      rid_mem[wr_ptr_q]    <= rid_q;
      stream_mem[wr_ptr_q] <= stream_q;
      pt_mem[wr_ptr_q]     <= pt_q;
      flt_mem[wr_ptr_q]    <= flt_q;
    end
  end

  assign out_valid_o     = (count_q != '0);
  assign count_o         = count_q;
  assign ir_o            = ir_mem[rd_ptr_q];
  assign ip_o            = ip_mem[rd_ptr_q];
  assign pip_o           = pip_mem[rd_ptr_q];
  assign rid_o           = rid_mem[rd_ptr_q];
  assign stream_o        = stream_mem[rd_ptr_q];
  assign predict_taken_o = pt_mem[rd_ptr_q];
  assign fault_o         = flt_mem[rd_ptr_q];

endmodule

// File: doc/any1_ialign_q.md
Name: any1_ialign_q

Overview:
- Parametrised, buffered successor to the single-instruction aligner.
- Accepts one fetched cache line with its start IP over a valid/ready handshake.
- Walks the line slot by slot from the start IP and extracts consecutive fixed-width instructions, one per clock, into an output queue for decode.
- Generates alignment faults, honours predicted-taken lines and flushes on redirect.

Parameters:
- LINE_BITS, 512: cache line width; a multiple of INSN_BITS.
- INSN_BITS, 64: instruction width; a multiple of 32.
- AWID, 32: width of the IP and PIP fields.
- RID_W, 4: width of the reorder ID.
- DEPTH, 4: output queue entries; a power of two, at least 2.
- FLT_CODE, 8'h00: fault code placed in bits [23:16] of a fault word. All other bits of a fault word are zero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all in-flight work.
- line_valid_i  in  1  line offered.
- line_ready_o  out  1  line accepted when high together with line_valid_i.
- cacheline_i  in  LINE_BITS  fetched line.
- ip_i  in  AWID  IP of the first instruction to extract.
- pip_i  in  AWID  previous IP, passed through.
- rid_i  in  RID_W  reorder ID, passed through.
- stream_i  in  1  stream tag, passed through.
- predict_taken_i  in  1  branch predicted taken in this line.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  consumer pops the head.
- ir_o  out  INSN_BITS  instruction.
- ip_o  out  AWID  instruction IP.
- pip_o  out  AWID  PIP of the line.
- rid_o  out  RID_W  reorder ID of the line.
- stream_o  out  1  stream tag of the line.
- predict_taken_o  out  1  predict flag of the line.
- fault_o  out  1  head entry is an alignment fault.
- count_o  out  clog2(DEPTH)+1  queue occupancy.

Behaviour:
Derived values:
- IB = INSN_BITS/8 bytes per instruction.
- SLOTS = LINE_BITS/INSN_BITS slots per line.
- Byte offset ofs = ip[clog2(LINE_BITS/8)-1:0].
- Slot index = ofs/IB.

Reset (rst_ni low, asynchronous):
- State goes to IDLE and the queue empties.
- out_valid_o, fault_o, predict_taken_o and stream_o are 0; ir_o, ip_o, pip_o and rid_o are 0; count_o is 0.
- line_ready_o is 1 from the first cycle after release.
- Reset asserted mid-walk abandons the line without further pushes.

FSM states:
- IDLE:
  - line_ready_o = 1.
  - On handshake, the line and its metadata are registered and the state goes to WALK.
  - The current IP is set to ip_i and the slot counter to the slot index.
- WALK:
  - line_ready_o = 0.
  - Each cycle the queue is not full, one entry is pushed and the current IP advances by IB.
  - If ofs mod IB != 0 on entry: one fault entry is pushed with fault=1, ir = fault word, ip = ip_i, and the state then returns to IDLE.
  - If predict_taken is set: only one instruction is pushed, then IDLE.
  - Otherwise a slot is pushed each cycle, and the state returns to IDLE after the push of slot SLOTS-1.
  - The slot counter never wraps into the next line.
  - A full queue stalls WALK with no push and the IP held.

Timing and queue rules:
- The first push occurs on the clock edge after acceptance. The entry is visible at the head (out_valid_o=1) in the following cycle, giving 2-cycle latency from acceptance to output.
- There is a 1-cycle IDLE bubble between lines.
- The queue is FIFO with registered outputs.
- A pop occurs when out_valid_o && out_ready_i.
- A push is blocked whenever count == DEPTH, even if a pop happens in the same cycle.
- A push and a pop in the same cycle on a non-full, non-empty queue leave count unchanged.
- A push into an empty queue with no pop makes the entry the head in the next cycle.

Flush and handshake rules:
- flush_i has highest priority and takes effect at the clock edge.
- On flush, the queue empties, the state goes to IDLE, and the push and any line handshake in that cycle are discarded.
- line_ready_o is still 1 in IDLE during flush, but the offered line is not captured.
- ir_o and the metadata outputs may be held or changed while out_valid_o=0, but must not change while out_valid_o=1 and out_ready_i=0.

Test Plan:
- Defaults, ip_i=32'h1000 (slot 0), line slots holding 0..7, out_ready_i=1 -> 8 entries, ir 0..7, ip 1000..1038 step 8. First out_valid_o 2 cycles after the handshake; line_ready_o low for 8 cycles.
- ip_i=32'h1030, predict_taken_i=0 -> 2 entries (slots 6 and 7, ip 1030 and 1038), then line_ready_o=1. With predict_taken_i=1 instead -> 1 entry, predict_taken_o=1.
- ip_i=32'h1004 -> single entry: fault_o=1, ir_o = {40'h0, FLT_CODE, 16'h0}, ip_o=1004.
- out_ready_i=0 from slot 0 -> count_o saturates at 4 and WALK stalls. Release out_ready_i -> remaining slots 4..7 delivered in order, none lost or duplicated.
- flush_i pulsed while WALK is at slot 3 with count 2 -> next cycle count_o=0, out_valid_o=0, line_ready_o=1. A new line is then accepted normally.
- rst_ni driven low mid-walk, asynchronous to clk_i -> outputs zero immediately. After release, line_ready_o=1 and count_o=0.
